seq_multiplier: RTL

//   Unsigned sequential shift-and-add multiplier. It is the companion of the restoring-divider

---
 rtl/seq_multiplier_if.sv | 28 ++
 rtl/seq_multiplier.sv | 113 +++++++++++
 2 files changed

// File: rtl/seq_multiplier_if.sv
// Handshake bundle for the sequential shift-and-add multiplier.
//   start        : request, sampled by the multiplier on each rising clock edge
//   multiplicand : operand A, captured when start is accepted
//   multiplier   : operand B, captured when start is accepted
//   product      : registered A*B, held until the next result
//   busy         : high while an operation is iterating
//   valid        : one-cycle pulse marking a freshly written product
// master drives the request and operands; slave (the multiplier) drives the results.
interface seq_multiplier_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;
  logic                 valid;

  modport master (
    output start, multiplicand, multiplier,
    input  product, busy, valid
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output product, busy, valid
  );
endinterface

// File: rtl/seq_multiplier.sv
// Unsigned sequential shift-and-add multiplier, one partial-product bit per clock.
// Controller FSM, iteration counter and A/ACC/Q datapath are all in this module.
//   clk   : rising-edge clock
//   reset : synchronous, active-low; aborts any operation in flight
//   bus   : seq_multiplier_if slave modport (start, multiplicand, multiplier in;
//           product, busy, valid out, all registered)
// Timing: start accepted at edge k -> WIDTH iterations -> product/valid updated at
// edge k+WIDTH. With start held high a new operation is captured from DONE, giving
// one result every WIDTH+1 cycles.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  seq_multiplier_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_count;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]     r_q;
  logic [2*WIDTH-1:0]   r_product;
  logic                 r_busy;
  logic                 r_valid;

  logic [WIDTH-1:0]     w_addend;
  logic [WIDTH:0]       w_sum;

  // Iteration adder: one extra bit keeps the carry, which becomes the new ACC MSB
  // after the right shift of {C,ACC,Q}.
  always_comb begin
    w_addend = '0;
    if (r_q[0]) begin
      w_addend = r_a;
    end
    w_sum = {1'b0, r_acc} + {1'b0, w_addend};
  end

  // Controller and datapath. Only control state and the visible outputs are reset;
  // A/ACC/Q are always reloaded when an operation is accepted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_product <= '0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_valid <= 1'b0;
          if (bus.start) begin
            r_a     <= bus.multiplicand;
            r_q     <= bus.multiplier;
            r_acc   <= '0;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end

        ST_RUN: begin
          r_acc   <= w_sum[WIDTH:1];
          r_q     <= {w_sum[0], r_q[WIDTH-1:1]};
          r_count <= r_count + 1'b1;
          if (r_count == LAST_ITER) begin
            // Final shifted {ACC,Q} is the product; register it directly so the
            // output changes only on the edge entering DONE.
            r_product <= {w_sum, r_q[WIDTH-1:1]};
            r_busy    <= 1'b0;
            r_valid   <= 1'b1;
            r_state   <= ST_DONE;
          end
        end

        ST_DONE: begin
          r_valid <= 1'b0;
          if (bus.start) begin
            r_a     <= bus.multiplicand;
            r_q     <= bus.multiplier;
            r_acc   <= '0;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.product = r_product;
  assign bus.busy    = r_busy;
  assign bus.valid   = r_valid;

endmodule
